// File: rtl/axis_log_decoder.sv
// Byte-wide AXI-Stream receiver for change-detection telemetry records.
// Reassembles little-endian records, computes the change delta and checks packet framing.
module axis_log_decoder #(
  parameter int FIFO_WIDTH  = 32,
  parameter int SIG_WIDTH   = 16,
  parameter int PACKET_SIZE = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic                            s_tlast,
  input  logic                            s_tkeep,
  input  logic [7:0]                      s_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [SIG_WIDTH-1:0]            m_change,
  output logic [FIFO_WIDTH-SIG_WIDTH-1:0] m_ignore,
  output logic [SIG_WIDTH-1:0]            m_delta,
  output logic                            err_o,
  output logic [7:0]                      err_count_o
);

  localparam int KEEP_WIDTH = FIFO_WIDTH / 8;
  localparam int IW         = $clog2(KEEP_WIDTH);
  localparam int RW         = $clog2(PACKET_SIZE);
  localparam logic [IW-1:0] IDX_LAST  = IW'(KEEP_WIDTH - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(PACKET_SIZE - 1);

  logic [IW-1:0]           idx;
  logic [RW-1:0]           rcnt;
  logic [SIG_WIDTH-1:0]    prev;
  logic [FIFO_WIDTH-9:0]   asm_q;
  logic [FIFO_WIDTH-1:0]   record;
  logic                    last_byte, kept, complete, misalign, short_err, long_err, err_now;

  assign last_byte = (idx == IDX_LAST);
  assign s_tready  = reset_n && !(m_tvalid && !m_tready && last_byte);
  assign kept      = s_tvalid && s_tready && s_tkeep;
  assign complete  = kept && last_byte;
  assign misalign  = kept && s_tlast && !last_byte;
  assign short_err = complete && s_tlast && (rcnt != RCNT_LAST);
  assign long_err  = complete && !s_tlast && (rcnt == RCNT_LAST);
  assign err_now   = short_err || long_err || misalign;

  // Bytes shift in from the top, so after KEEP_WIDTH-1 kept bytes asm_q holds them
  // LSB-first with no index decode; stale bytes from a discarded record shift out.
  assign record = {s_tdata, asm_q};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx         <= '0;
      rcnt        <= '0;
      prev        <= '1;
      asm_q       <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_change    <= '0;
      m_ignore    <= '0;
      m_delta     <= '0;
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      if (m_tready)
        m_tvalid <= 1'b0;
      if (complete) begin
        m_tvalid <= 1'b1;
        m_tlast  <= s_tlast;
        m_change <= record[SIG_WIDTH-1:0];
        m_ignore <= record[FIFO_WIDTH-1:SIG_WIDTH];
        m_delta  <= record[SIG_WIDTH-1:0] ^ prev;
        prev     <= record[SIG_WIDTH-1:0];
      end

      err_o <= err_now;
      if (err_now && (err_count_o != 8'hFF))
        err_count_o <= err_count_o + 8'd1;

      if (kept) begin
        if (last_byte) begin
          idx  <= '0;
          rcnt <= s_tlast ? '0 : rcnt + 1'b1;
        end else if (s_tlast) begin
          idx  <= '0;
          rcnt <= '0;
        end else begin
          idx   <= idx + 1'b1;
          asm_q <= record[FIFO_WIDTH-1:8];
        end
      end
    end
  end

endmodule
